// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings, state enum and control bundle for the multicycle controller
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_SLT  = 3'b011;
   localparam logic [2:0] ALU_SLTU = 3'b100;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   typedef enum logic [3:0] {
      IFETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I,
      ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP
   } state_t;

   typedef struct packed {
      logic       pc_wr;
      logic       pc_wr_cond;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_wr;
      logic       reg_wr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       illegal;
      logic       instr_done;
   } ctrl_t;

   function automatic logic is_r_funct(input logic [5:0] funct);
      return funct inside {FN_ADD, FN_SUB, FN_SUBU, FN_SLT, FN_SLTU};
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - datapath/controller bundle; master is the datapath side
interface multicycle_controller_if;

   logic [31:0] Instruction;
   logic        Zero;
   logic        mem_ready;
   logic        PCWr;
   logic        PCWrCond;
   logic [1:0]  PCSrc;
   logic        IorD;
   logic        MemRd;
   logic        MemWr;
   logic        IRWr;
   logic        RegWr;
   logic        RegDst;
   logic        MemtoReg;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic        ExtOp;
   logic [2:0]  ALUctr;
   logic        illegal;
   logic        instr_done;

   modport master (
      output Instruction, Zero, mem_ready,
      input  PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegWr, RegDst,
             MemtoReg, ALUSrcA, ALUSrcB, ExtOp, ALUctr, illegal, instr_done
   );

   modport slave (
      input  Instruction, Zero, mem_ready,
      output PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegWr, RegDst,
             MemtoReg, ALUSrcA, ALUSrcB, ExtOp, ALUctr, illegal, instr_done
   );

endinterface

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - ALU operation and immediate-extension select per state
module mc_alu_decode
   import mc_pkg::*;
(
   input  state_t      state_i,
   input  logic [5:0]  opcode_i,
   input  logic [5:0]  funct_i,
   output logic [2:0]  alu_ctr_o,
   output logic        ext_op_o
);

   always_comb begin
      alu_ctr_o = ALU_ADD;
      ext_op_o  = 1'b0;
      case (state_i)
         DECODE, ADDR: ext_op_o = 1'b1;
         EXEC_R: begin
            case (funct_i)
               FN_SUB, FN_SUBU: alu_ctr_o = ALU_SUB;
               FN_SLT:          alu_ctr_o = ALU_SLT;
               FN_SLTU:         alu_ctr_o = ALU_SLTU;
               default:         alu_ctr_o = ALU_ADD;
            endcase
         end
         EXEC_I: begin
            if (opcode_i == OP_ORI) alu_ctr_o = ALU_OR;
            else                    ext_op_o  = 1'b1;
         end
         BRANCH:  alu_ctr_o = ALU_SUB;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset sequencer driving shared ALU/memory datapath
module multicycle_controller
   import mc_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   multicycle_controller_if.slave        bus
);

   state_t      state_q, state_d;
   ctrl_t       ctl;
   ctrl_t       ctl_out;
   logic [2:0]  alu_ctr;
   logic        ext_op;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        is_nop;
   logic        legal;
   logic        unused_zero;

   assign opcode      = bus.Instruction[31:26];
   assign funct       = bus.Instruction[5:0];
   assign is_nop      = (bus.Instruction == 32'd0);
   assign legal       = ((opcode == OP_RTYPE) && is_r_funct(funct)) ||
                        (opcode inside {OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J});
   // Zero is consumed by the datapath together with PCWrCond
   assign unused_zero = bus.Zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IFETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctl     = '0;
      case (state_q)
         IFETCH: begin
            ctl.mem_rd    = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            ctl.pc_src    = PCSRC_ALU;
            if (bus.mem_ready) begin
               ctl.pc_wr = 1'b1;
               ctl.ir_wr = 1'b1;
               state_d   = DECODE;
            end
         end
         DECODE: begin
            ctl.alu_src_b = SRCB_BOFF;
            if (is_nop) begin
               ctl.instr_done = 1'b1;
               state_d        = IFETCH;
            end else if (!legal) begin
               ctl.illegal    = 1'b1;
               ctl.instr_done = 1'b1;
               state_d        = IFETCH;
            end else begin
               case (opcode)
                  OP_RTYPE:        state_d = EXEC_R;
                  OP_ORI, OP_ADDIU: state_d = EXEC_I;
                  OP_LW, OP_SW:    state_d = ADDR;
                  OP_BEQ:          state_d = BRANCH;
                  default:         state_d = JUMP;
               endcase
            end
         end
         EXEC_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_RT;
            state_d       = WB_R;
         end
         EXEC_I: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            state_d       = WB_I;
         end
         WB_R, WB_I: begin
            ctl.reg_wr     = 1'b1;
            ctl.reg_dst    = (state_q == WB_R);
            ctl.instr_done = 1'b1;
            state_d        = IFETCH;
         end
         ADDR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            state_d       = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            ctl.mem_rd = 1'b1;
            ctl.i_or_d = 1'b1;
            if (bus.mem_ready) state_d = WB_MEM;
         end
         WB_MEM: begin
            ctl.reg_wr     = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = IFETCH;
         end
         MEM_WR: begin
            ctl.mem_wr = 1'b1;
            ctl.i_or_d = 1'b1;
            if (bus.mem_ready) begin
               ctl.instr_done = 1'b1;
               state_d        = IFETCH;
            end
         end
         BRANCH: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_src_b  = SRCB_RT;
            ctl.pc_wr_cond = 1'b1;
            ctl.pc_src     = PCSRC_ALUOUT;
            ctl.instr_done = 1'b1;
            state_d        = IFETCH;
         end
         JUMP: begin
            ctl.pc_wr      = 1'b1;
            ctl.pc_src     = PCSRC_JUMP;
            ctl.instr_done = 1'b1;
            state_d        = IFETCH;
         end
         default: state_d = IFETCH;
      endcase
   end

   mc_alu_decode u_alu_decode (
      .state_i   (state_q),
      .opcode_i  (opcode),
      .funct_i   (funct),
      .alu_ctr_o (alu_ctr),
      .ext_op_o  (ext_op)
   );

   // Reset silences every control line, including the IFETCH read
   assign ctl_out        = rst ? '0 : ctl;
   assign bus.PCWr       = ctl_out.pc_wr;
   assign bus.PCWrCond   = ctl_out.pc_wr_cond;
   assign bus.PCSrc      = ctl_out.pc_src;
   assign bus.IorD       = ctl_out.i_or_d;
   assign bus.MemRd      = ctl_out.mem_rd;
   assign bus.MemWr      = ctl_out.mem_wr;
   assign bus.IRWr       = ctl_out.ir_wr;
   assign bus.RegWr      = ctl_out.reg_wr;
   assign bus.RegDst     = ctl_out.reg_dst;
   assign bus.MemtoReg   = ctl_out.mem_to_reg;
   assign bus.ALUSrcA    = ctl_out.alu_src_a;
   assign bus.ALUSrcB    = ctl_out.alu_src_b;
   assign bus.illegal    = ctl_out.illegal;
   assign bus.instr_done = ctl_out.instr_done;
   assign bus.ExtOp      = rst ? 1'b0 : ext_op;
   assign bus.ALUctr     = rst ? 3'b000 : alu_ctr;

endmodule
